// File: rtl/stp_fsm_3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stp_fsm_3_pkg
// Description : Shared constants for the store-polynomial engine: state
//               encodings, coefficient-store geometry, status codes and a
//               ceiling-log2 helper for sizing buffer addresses.
// Ports       : none (package)
// Revision    : 1.0  initial release
// ============================================================================
package stp_fsm_3_pkg;

  // State encodings (3-bit)
  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_CHECK = 3'd1;
  localparam logic [2:0] c_ST_READ  = 3'd2;
  localparam logic [2:0] c_ST_WRITE = 3'd3;
  localparam logic [2:0] c_ST_ERROR = 3'd4;
  localparam logic [2:0] c_ST_END   = 3'd5;

  // Coefficient store geometry: 8 slots of up to 11 coefficients each
  localparam logic [4:0] c_MAX_DEGREE  = 5'd10;
  localparam logic [7:0] c_SLOT_STRIDE = 8'd11;

  // Status word values
  localparam logic [31:0] c_STATUS_OK    = 32'h0000_0000;
  localparam logic [31:0] c_STATUS_BAD_N = 32'h0000_0002;
  localparam logic [31:0] c_STATUS_IDLE  = 32'hFFFF_FFFF;

  // Ceiling log2; returns 0 for values of 0 or 1
  function automatic int clog2_fn(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >>> 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stp_fsm_3.sv
`default_nettype none
// ============================================================================
// Module      : stp_fsm_3
// Description : Store-polynomial engine. On start_stp it copies N+1 16-bit
//               coefficients from the data buffer into S memory at slot A
//               (address A*11+i), then writes the degree N into N memory at
//               address A and pulses done_stp.
// Ports       :
//   clk                  in   clock, rising edge
//   rst                  in   asynchronous active-low reset
//   rst_instr            in   synchronous active-low instruction abort
//   start_stp            in   start request, honoured only in IDLE
//   A / N                in   slot (0..7) / degree (legal 0..10)
//   rd_addr_data         in   buffer address of the first coefficient
//   data_in              in   buffer read data, valid 1 cycle after en_rd_data
//   en_rd_data           out  buffer read enable
//   rd_addr_data_updated out  buffer read address / next unread address
//   en_wr_S/wr_addr_S/wr_data_S  out  S memory write port
//   en_wr_N/wr_addr_N/wr_data_N  out  N memory write port
//   done_stp             out  one-cycle completion pulse
//   status               out  0 ok, 2 bad degree, all-ones idle/never run
// Revision    : 1.0  initial release
// ============================================================================
module stp_fsm_3
  import stp_fsm_3_pkg::*;
#(
  parameter  int BUFFER_SIZE = 1024,
  localparam int AW          = clog2_fn(BUFFER_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rst_instr,
  input  logic          start_stp,
  input  logic [2:0]    A,
  input  logic [4:0]    N,
  input  logic [AW-1:0] rd_addr_data,
  input  logic [15:0]   data_in,
  output logic          en_rd_data,
  output logic [AW-1:0] rd_addr_data_updated,
  output logic          en_wr_S,
  output logic [7:0]    wr_addr_S,
  output logic [15:0]   wr_data_S,
  output logic          en_wr_N,
  output logic [2:0]    wr_addr_N,
  output logic [4:0]    wr_data_N,
  output logic          done_stp,
  output logic [31:0]   status
);

  localparam logic [AW:0] c_BUF_SIZE = (AW+1)'(BUFFER_SIZE);

  // Buffer address arithmetic wraps modulo BUFFER_SIZE (need not be a power of two)
  function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] base, input logic [4:0] off);
    logic [AW:0] sum;
    sum = {1'b0, base} + (AW+1)'(off);
    if (sum >= c_BUF_SIZE) sum = sum - c_BUF_SIZE;
    return sum[AW-1:0];
  endfunction

  // Control state
  logic [2:0]    state_q, state_d;
  logic [3:0]    i_q, i_d;
  logic [2:0]    a_q, a_d;
  logic [4:0]    n_q, n_d;
  logic [AW-1:0] base_q, base_d;
  logic [7:0]    slot_q, slot_d;

  // Registered outputs
  logic          en_rd_q, en_rd_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          en_wr_s_q, en_wr_s_d;
  logic [7:0]    wr_addr_s_q, wr_addr_s_d;
  logic          en_wr_n_q, en_wr_n_d;
  logic [2:0]    wr_addr_n_q, wr_addr_n_d;
  logic [4:0]    wr_data_n_q, wr_data_n_d;
  logic          done_q, done_d;
  logic [31:0]   status_q, status_d;

  // --------------------------------------------------------------------------
  // State / output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= c_ST_IDLE;
      i_q         <= '0;
      a_q         <= '0;
      n_q         <= '0;
      base_q      <= '0;
      slot_q      <= '0;
      en_rd_q     <= 1'b0;
      rd_addr_q   <= '0;
      en_wr_s_q   <= 1'b0;
      wr_addr_s_q <= '0;
      en_wr_n_q   <= 1'b0;
      wr_addr_n_q <= '0;
      wr_data_n_q <= '0;
      done_q      <= 1'b0;
      status_q    <= c_STATUS_IDLE;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      a_q         <= a_d;
      n_q         <= n_d;
      base_q      <= base_d;
      slot_q      <= slot_d;
      en_rd_q     <= en_rd_d;
      rd_addr_q   <= rd_addr_d;
      en_wr_s_q   <= en_wr_s_d;
      wr_addr_s_q <= wr_addr_s_d;
      en_wr_n_q   <= en_wr_n_d;
      wr_addr_n_q <= wr_addr_n_d;
      wr_data_n_q <= wr_data_n_d;
      done_q      <= done_d;
      status_q    <= status_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    a_d     = a_q;
    n_d     = n_q;
    base_d  = base_q;
    slot_d  = slot_q;
    case (state_q)
      c_ST_IDLE: begin
        if (start_stp) begin
          state_d = c_ST_CHECK;
          a_d     = A;
          n_d     = N;
          base_d  = rd_addr_data;
          slot_d  = {5'b0, A} * c_SLOT_STRIDE;
        end
      end
      c_ST_CHECK: begin
        if (n_q > c_MAX_DEGREE) begin
          state_d = c_ST_ERROR;
        end else begin
          state_d = c_ST_READ;
          i_d     = '0;
        end
      end
      c_ST_READ:  state_d = c_ST_WRITE;
      c_ST_WRITE: begin
        if ({1'b0, i_q} == n_q) begin
          state_d = c_ST_END;
        end else begin
          state_d = c_ST_READ;
          i_d     = i_q + 4'd1;
        end
      end
      c_ST_ERROR: state_d = c_ST_END;
      c_ST_END:   state_d = c_ST_IDLE;
      default:    state_d = c_ST_IDLE;
    endcase
    if (!rst_instr) begin
      state_d = c_ST_IDLE;
      i_d     = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Output logic: outputs are decoded from the state being entered so they
  // are registered yet line up with that state's cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    en_rd_d     = 1'b0;
    en_wr_s_d   = 1'b0;
    en_wr_n_d   = 1'b0;
    done_d      = 1'b0;
    rd_addr_d   = rd_addr_q;
    wr_addr_s_d = wr_addr_s_q;
    wr_addr_n_d = wr_addr_n_q;
    wr_data_n_d = wr_data_n_q;
    status_d    = status_q;
    case (state_d)
      c_ST_READ: begin
        en_rd_d   = 1'b1;
        rd_addr_d = wrap_add(base_q, {1'b0, i_d});
      end
      c_ST_WRITE: begin
        en_wr_s_d   = 1'b1;
        wr_addr_s_d = slot_q + {4'b0, i_d};
      end
      c_ST_END: begin
        done_d = 1'b1;
        if (state_q == c_ST_ERROR) begin
          status_d = c_STATUS_BAD_N;
        end else begin
          en_wr_n_d   = 1'b1;
          wr_addr_n_d = a_q;
          wr_data_n_d = n_q;
          status_d    = c_STATUS_OK;
          // Leave the pointer at the first unread buffer word
          rd_addr_d   = wrap_add(base_q, n_q + 5'd1);
        end
      end
      default: ;
    endcase
    if (!rst_instr) begin
      en_rd_d     = 1'b0;
      en_wr_s_d   = 1'b0;
      en_wr_n_d   = 1'b0;
      done_d      = 1'b0;
      rd_addr_d   = '0;
      wr_addr_s_d = '0;
      wr_addr_n_d = '0;
      wr_data_n_d = '0;
      status_d    = c_STATUS_IDLE;
    end
  end

  assign en_rd_data           = en_rd_q;
  assign rd_addr_data_updated = rd_addr_q;
  assign en_wr_S              = en_wr_s_q;
  assign wr_addr_S            = wr_addr_s_q;
  // Buffer data arrives during the WRITE cycle, so it is forwarded straight
  // to the S port rather than registered a second time.
  assign wr_data_S            = en_wr_s_q ? data_in : 16'h0000;
  assign en_wr_N              = en_wr_n_q;
  assign wr_addr_N            = wr_addr_n_q;
  assign wr_data_N            = wr_data_n_q;
  assign done_stp             = done_q;
  assign status               = status_q;

endmodule
`default_nettype wire

// File: tb/tb_stp_fsm_3.sv
`default_nettype none
// ============================================================================
// Module      : tb_stp_fsm_3
// Description : Self-checking bench for stp_fsm_3. Models the data buffer,
//               S memory and N memory, and compares each transfer against the
//               expected copy of buffer words into the coefficient store.
// Revision    : 1.0  initial release
// ============================================================================
module tb_stp_fsm_3;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          rst_instr;
  logic          start_stp;
  logic [2:0]    A;
  logic [4:0]    N;
  logic [AW-1:0] rd_addr_data;
  logic [15:0]   data_in = '0;
  logic          en_rd_data;
  logic [AW-1:0] rd_addr_data_updated;
  logic          en_wr_S;
  logic [7:0]    wr_addr_S;
  logic [15:0]   wr_data_S;
  logic          en_wr_N;
  logic [2:0]    wr_addr_N;
  logic [4:0]    wr_data_N;
  logic          done_stp;
  logic [31:0]   status;

  always #5 clk = ~clk;

  stp_fsm_3 #(.BUFFER_SIZE(1024)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .rst_instr            (rst_instr),
    .start_stp            (start_stp),
    .A                    (A),
    .N                    (N),
    .rd_addr_data         (rd_addr_data),
    .data_in              (data_in),
    .en_rd_data           (en_rd_data),
    .rd_addr_data_updated (rd_addr_data_updated),
    .en_wr_S              (en_wr_S),
    .wr_addr_S            (wr_addr_S),
    .wr_data_S            (wr_data_S),
    .en_wr_N              (en_wr_N),
    .wr_addr_N            (wr_addr_N),
    .wr_data_N            (wr_data_N),
    .done_stp             (done_stp),
    .status               (status)
  );

  // Memories around the engine; tags record which transfer wrote each entry
  logic [15:0] buffer [1024];
  logic [15:0] s_mem  [256];
  int          s_tag  [256];
  logic [4:0]  n_mem  [8];
  int          n_tag  [8];

  int cur_txn   = 0;
  int n_wr_s    = 0;
  int n_wr_n    = 0;
  int n_done    = 0;
  int n_overlap = 0;
  int checks    = 0;
  int errors    = 0;

  always @(posedge clk) begin
    if (en_rd_data) data_in <= buffer[rd_addr_data_updated];
    if (en_wr_S) begin
      s_mem[wr_addr_S] <= wr_data_S;
      s_tag[wr_addr_S] <= cur_txn;
      n_wr_s++;
    end
    if (en_wr_N) begin
      n_mem[wr_addr_N] <= wr_data_N;
      n_tag[wr_addr_N] <= cur_txn;
      n_wr_n++;
    end
    if (done_stp) n_done++;
    if (en_rd_data && en_wr_S) n_overlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Degree-n polynomial value at x with coefficient i taken from buffer[(base+i)%1024]
  function automatic int unsigned poly_ref(input int base, input int n, input int unsigned x);
    int unsigned acc = 0;
    for (int i = n; i >= 0; i--) acc = acc * x + buffer[(base + i) % 1024];
    return acc;
  endfunction

  function automatic int unsigned poly_store(input int a, input int n, input int unsigned x);
    int unsigned acc = 0;
    for (int i = n; i >= 0; i--) acc = acc * x + s_mem[a * 11 + i];
    return acc;
  endfunction

  // One STP transfer; expected timing: done_stp in cycle 2N+4 (3 on bad degree),
  // counting the cycle after the start-sampling edge as cycle 1.
  task automatic run_txn(input logic [2:0] a, input logic [4:0] n, input logic [9:0] base, input bit hold);
    int  s0, w0, d0, cyc, idx;
    bit  ok;
    cur_txn++;
    s0 = n_wr_s; w0 = n_wr_n; d0 = n_done;
    ok = (n <= 5'd10);
    @(negedge clk);
    A = a; N = n; rd_addr_data = base; start_stp = 1'b1;
    @(posedge clk); #1;
    if (!hold) start_stp = 1'b0;
    cyc = 1;
    while (!done_stp && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    start_stp = 1'b0;
    check("done_cycle", cyc, ok ? 2 * n + 4 : 3);
    if (ok) check("final_rd_addr", {22'b0, rd_addr_data_updated}, (base + n + 1) % 1024);
    @(posedge clk); #1;
    check("status", status, ok ? 32'd0 : 32'd2);
    check("s_write_count", n_wr_s - s0, ok ? n + 1 : 0);
    check("n_write_count", n_wr_n - w0, ok ? 1 : 0);
    check("done_pulses", n_done - d0, 1);
    check("rd_wr_overlap", n_overlap, 0);
    if (ok) begin
      check("n_mem_tag", n_tag[a], cur_txn);
      check("n_mem_data", {27'b0, n_mem[a]}, {27'b0, n});
      for (int i = 0; i <= int'(n); i++) begin
        idx = a * 11 + i;
        check("s_mem_tag", s_tag[idx], cur_txn);
        check("s_mem_data", {16'b0, s_mem[idx]}, {16'b0, buffer[(base + i) % 1024]});
      end
    end
    if (hold) begin
      repeat (6) @(posedge clk);
      #1;
      check("hold_single_done", n_done - d0, 1);
      check("hold_single_writes", n_wr_s - s0, ok ? n + 1 : 0);
    end
  endtask

  initial begin
    int s0, w0, d0, cyc;
    rst = 1'b0; rst_instr = 1'b1; start_stp = 1'b0;
    A = '0; N = '0; rd_addr_data = '0;
    for (int k = 0; k < 1024; k++) buffer[k] = 16'($urandom);
    buffer[5] = 16'd1; buffer[6] = 16'd2; buffer[7] = 16'd3; buffer[8] = 16'd4;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_status", status, 32'hFFFF_FFFF);
    check("rst_en_rd", {31'b0, en_rd_data}, 32'd0);
    check("rst_en_wr_S", {31'b0, en_wr_S}, 32'd0);
    check("rst_en_wr_N", {31'b0, en_wr_N}, 32'd0);
    check("rst_done", {31'b0, done_stp}, 32'd0);
    check("rst_rd_addr", {22'b0, rd_addr_data_updated}, 32'd0);
    check("rst_wr_addr_S", {24'b0, wr_addr_S}, 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_status", status, 32'hFFFF_FFFF);

    // Directed cases
    run_txn(3'd2, 5'd3, 10'd5, 1'b0);
    run_txn(3'd7, 5'd0, 10'd100, 1'b0);
    run_txn(3'd1, 5'd11, 10'd10, 1'b0);
    run_txn(3'd4, 5'd2, 10'd1023, 1'b0);
    run_txn(3'd5, 5'd10, 10'd500, 1'b0);

    // Abort after the second coefficient write
    cur_txn++;
    s0 = n_wr_s; w0 = n_wr_n; d0 = n_done;
    @(negedge clk);
    A = 3'd3; N = 5'd5; rd_addr_data = 10'd200; start_stp = 1'b1;
    @(posedge clk); #1;
    start_stp = 1'b0;
    cyc = 0;
    while ((n_wr_s - s0) < 2 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abort_reached_2nd_write", n_wr_s - s0, 2);
    rst_instr = 1'b0;
    @(posedge clk); #1;
    rst_instr = 1'b1;
    check("abort_status", status, 32'hFFFF_FFFF);
    check("abort_en_rd", {31'b0, en_rd_data}, 32'd0);
    check("abort_en_wr_S", {31'b0, en_wr_S}, 32'd0);
    check("abort_done", {31'b0, done_stp}, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", n_done - d0, 0);
    check("abort_no_n_write", n_wr_n - w0, 0);
    check("abort_s_writes", n_wr_s - s0, 2);
    check("abort_s0", {16'b0, s_mem[33]}, {16'b0, buffer[200]});
    check("abort_s1", {16'b0, s_mem[34]}, {16'b0, buffer[201]});
    check("abort_s1_tag", s_tag[34], cur_txn);

    // start_stp held for the whole transfer, then evaluate the stored slot
    run_txn(3'd6, 5'd4, 10'd300, 1'b1);
    check("poly_eval", poly_store(6, 4, 32'd3), poly_ref(300, 4, 32'd3));

    // Randomized transfers, including illegal degrees
    for (int t = 0; t < 12; t++) begin
      run_txn(3'($urandom_range(0, 7)), 5'($urandom_range(0, 13)),
              10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
